// File: rtl/key_length_entry.sv
// key_length_entry: keypad length-entry controller.
// Builds a multi-digit decimal wire length from successive key strobes,
// range-checks it on ENT and holds the committed length for the stepper
// pulse generator. Command keys produce one-cycle pulses or toggle the
// LOCKED state. Every output is a register; responses appear one clock
// after the key_valid cycle.

module key_length_entry #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MIN_LEN = 1,
    parameter int unsigned MAX_LEN = 9999
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         key_valid,
    input  logic [3:0]                   num,
    output logic [WIDTH-1:0]             entry,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic [WIDTH-1:0]             length,
    output logic                         length_valid,
    output logic                         commit,
    output logic                         go,
    output logic                         stop,
    output logic                         locked,
    output logic                         err
);

    localparam int unsigned CW = $clog2(DIGITS + 1);

    // Digit-count and range limits at the datapath widths, so every
    // comparison below is width-matched.
    localparam logic [CW-1:0]    DIGITS_C = CW'(DIGITS);
    localparam logic [CW-1:0]    ONE_C    = CW'(1);
    localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(MIN_LEN);
    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_LEN);

    // Key codes above the digit range.
    localparam logic [3:0] KEY_STOP = 4'd10;
    localparam logic [3:0] KEY_GO   = 4'd11;
    localparam logic [3:0] KEY_LOCK = 4'd12;
    localparam logic [3:0] KEY_ENT  = 4'd13;
    localparam logic [3:0] KEY_ESC  = 4'd14;
    localparam logic [3:0] KEY_PWR  = 4'd15;

    // IDLE and ENTRY differ only in whether digits are pending; LOCKED
    // freezes the entry and blocks run requests.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e              state_q;
    logic [WIDTH-1:0]    entry_q;
    logic [CW-1:0]       digit_count_q;
    logic [WIDTH-1:0]    length_q;
    logic                length_valid_q;
    logic                commit_q;
    logic                go_q;
    logic                stop_q;
    logic                locked_q;
    logic                err_q;

    // Next-value helpers derived from the current registers and key.
    logic [WIDTH-1:0]    entry_append_d;
    logic [CW-1:0]       digit_count_inc_d;
    logic                is_digit_d;
    logic                digits_full_d;
    logic                entry_in_range_d;
    logic                entry_present_d;

    // Arithmetic and qualifiers for the digit and ENT keys.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        entry_append_d    = '0;
        digit_count_inc_d = '0;
        is_digit_d        = 1'b0;
        digits_full_d     = 1'b0;
        entry_in_range_d  = 1'b0;
        entry_present_d   = 1'b0;

        // entry*10 + d as shift-and-add, truncated to WIDTH.
        entry_append_d    = (entry_q << 3) + (entry_q << 1)
                          + {{(WIDTH-4){1'b0}}, num};
        digit_count_inc_d = digit_count_q + ONE_C;
        is_digit_d        = (num <= 4'd9);
        digits_full_d     = (digit_count_q == DIGITS_C);
        entry_present_d   = (digit_count_q != '0);
        entry_in_range_d  = (entry_q >= MIN_W) && (entry_q <= MAX_W);
    end

    // Key-decoding FSM with registered datapath and pulse outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q        <= ST_IDLE;
            entry_q        <= '0;
            digit_count_q  <= '0;
            length_q       <= '0;
            length_valid_q <= 1'b0;
            commit_q       <= 1'b0;
            go_q           <= 1'b0;
            stop_q         <= 1'b0;
            locked_q       <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-armed below.
            commit_q <= 1'b0;
            go_q     <= 1'b0;
            stop_q   <= 1'b0;
            err_q    <= 1'b0;

            if (key_valid) begin
                if (state_q == ST_LOCKED) begin
                    // Only STOP and LOCK act while locked; the rest are
                    // silently ignored.
                    case (num)
                        KEY_STOP: stop_q <= 1'b1;
                        KEY_LOCK: begin
                            locked_q <= 1'b0;
                            state_q  <= entry_present_d ? ST_ENTRY : ST_IDLE;
                        end
                        default: ;
                    endcase
                end else if (is_digit_d) begin
                    if (digits_full_d) begin
                        err_q <= 1'b1;
                    end else begin
                        entry_q       <= entry_append_d;
                        digit_count_q <= digit_count_inc_d;
                        state_q       <= ST_ENTRY;
                    end
                end else begin
                    case (num)
                        KEY_STOP: stop_q <= 1'b1;
                        KEY_GO: begin
                            if (length_valid_q) go_q  <= 1'b1;
                            else                err_q <= 1'b1;
                        end
                        KEY_LOCK: begin
                            // Entry and digit count survive the lock.
                            locked_q <= 1'b1;
                            state_q  <= ST_LOCKED;
                        end
                        KEY_ENT: begin
                            if (entry_present_d && entry_in_range_d) begin
                                length_q       <= entry_q;
                                length_valid_q <= 1'b1;
                                commit_q       <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                            entry_q       <= '0;
                            digit_count_q <= '0;
                            state_q       <= ST_IDLE;
                        end
                        KEY_ESC: begin
                            entry_q       <= '0;
                            digit_count_q <= '0;
                            state_q       <= ST_IDLE;
                        end
                        KEY_PWR: begin
                            entry_q        <= '0;
                            digit_count_q  <= '0;
                            length_q       <= '0;
                            length_valid_q <= 1'b0;
                            state_q        <= ST_IDLE;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign entry        = entry_q;
    assign digit_count  = digit_count_q;
    assign length       = length_q;
    assign length_valid = length_valid_q;
    assign commit       = commit_q;
    assign go           = go_q;
    assign stop         = stop_q;
    assign locked       = locked_q;
    assign err          = err_q;

endmodule
